mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/tinker_mem_pkg.sv | 22 ++
 rtl/mem_arb_starve_ctr.sv | 37 +++
 rtl/mem_port_arbiter.sv | 113 +++++++++++
 tb/tb_mem_port_arbiter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinker_mem_pkg.sv
// Shared types, defaults and the address-range helper for the memory port arbiter.
package tinker_mem_pkg;

    localparam int unsigned MEM_BYTES_DEF    = 524288;
    localparam int unsigned STARVE_LIMIT_DEF = 4;

    typedef enum logic [1:0] {
        R_NONE = 2'd0,
        R_IF   = 2'd1,
        R_D    = 2'd2
    } resp_owner_t;

    // Widened to 65 bits so an access that wraps past 2^64 still reads as out of range.
    function automatic logic addr_oor(input logic [63:0] addr,
                                      input logic [3:0]  last_off,
                                      input logic [64:0] mem_bytes);
        logic [64:0] end_addr;
        end_addr = {1'b0, addr} + {61'd0, last_off};
        return (end_addr >= mem_bytes);
    endfunction

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch waits; flags when fetch is starved.
module mem_arb_starve_ctr
    import tinker_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic starved_o
);

    localparam int unsigned CW = $clog2(STARVE_LIMIT + 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != CW'(STARVE_LIMIT))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign starved_o = (cnt_q == CW'(STARVE_LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter onto one single-cycle memory port; data wins unless the optional
// fetch anti-starvation guard (MEM_ARB_STARVE_GUARD_EN) forces a fetch grant.
//
// state  | meaning
// R_NONE | no response due this cycle
// R_IF   | fetch response due this cycle
// R_D    | data response due this cycle
module mem_port_arbiter
    import tinker_mem_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int unsigned MEM_BYTES    = MEM_BYTES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [63:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [63:0] d_addr,
    input  logic [63:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [63:0] d_rdata,
    output logic        d_err,
    output logic        mem_en,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    input  logic [63:0] mem_rdata
);

    localparam logic [64:0] MEM_BYTES_W = 65'(MEM_BYTES);

    resp_owner_t state_q, state_d;
    logic        err_q, err_d;
    logic        store_q, store_d;
    logic        starved, if_win, if_oor, d_oor;

    assign if_oor = addr_oor(if_addr, 4'd3, MEM_BYTES_W);
    assign d_oor  = addr_oor(d_addr, 4'd7, MEM_BYTES_W);

`ifdef MEM_ARB_STARVE_GUARD_EN
    mem_arb_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve_ctr (
        .clk       (clk),
        .reset     (reset),
        .inc_i     (d_gnt & if_req),
        .clr_i     (if_gnt | ~if_req),
        .starved_o (starved)
    );
`else
    logic unused_limit;
    assign unused_limit = ^STARVE_LIMIT;
    assign starved      = 1'b0;
`endif

    // Grants are masked during reset so every output reads 0 while it is held.
    assign if_win = if_req & (~d_req | starved);
    assign if_gnt = ~reset & if_win;
    assign d_gnt  = ~reset & d_req & ~if_win;

    always_comb begin
        state_d   = R_NONE;
        err_d     = 1'b0;
        store_d   = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (if_gnt) begin
            state_d = R_IF;
            err_d   = if_oor;
            if (!if_oor) begin
                mem_en   = 1'b1;
                mem_addr = if_addr;
            end
        end else if (d_gnt) begin
            state_d = R_D;
            err_d   = d_oor;
            store_d = d_we;
            if (!d_oor) begin
                mem_en    = 1'b1;
                mem_we    = d_we;
                mem_addr  = d_addr;
                mem_wdata = d_we ? d_wdata : 64'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= R_NONE;
            err_q   <= 1'b0;
            store_q <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
            store_q <= store_d;
        end
    end

    assign if_rvalid = (state_q == R_IF);
    assign d_rvalid  = (state_q == R_D);
    assign if_err    = if_rvalid & err_q;
    assign d_err     = d_rvalid & err_q;
    assign if_rdata  = (if_rvalid & ~err_q) ? mem_rdata[31:0] : 32'd0;
    assign d_rdata   = (d_rvalid & ~err_q & ~store_q) ? mem_rdata : 64'd0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus a randomized run against a reference model.
module tb_mem_port_arbiter;

    localparam int unsigned     STARVE = 4;
    localparam longint unsigned MEMB   = 64'd524288;
`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic        clk, reset;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [63:0] if_addr;
    logic [31:0] if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [63:0] d_addr, d_wdata, d_rdata;
    logic        mem_en, mem_we;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;

    int checks = 0;
    int passes = 0;

    mem_port_arbiter #(.STARVE_LIMIT(STARVE), .MEM_BYTES(524288)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_gnt(d_gnt),
        .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory environment driven by the DUT bus; idle cycles return junk to expose stale data.
    logic [7:0] env_mem [longint unsigned];
    logic [7:0] ref_mem [longint unsigned];

    function automatic logic [63:0] env_rd64(input logic [63:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++)
            v[8*i +: 8] = env_mem.exists(a + 64'(i)) ? env_mem[a + 64'(i)] : 8'h00;
        return v;
    endfunction

    function automatic logic [63:0] ref_rd64(input logic [63:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++)
            v[8*i +: 8] = ref_mem.exists(a + 64'(i)) ? ref_mem[a + 64'(i)] : 8'h00;
        return v;
    endfunction

    always @(posedge clk) begin
        if (mem_en && mem_we) begin
            for (int i = 0; i < 8; i++) env_mem[mem_addr + 64'(i)] = mem_wdata[8*i +: 8];
            mem_rdata <= {$urandom, $urandom};
        end else if (mem_en) begin
            mem_rdata <= env_rd64(mem_addr);
        end else begin
            mem_rdata <= {$urandom, $urandom};
        end
    end

    task automatic idle_inputs();
        if_req = 1'b0; if_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        if_req = 1'b1; if_addr = 64'h40;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h40;
        repeat (2) @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== '0)
            $display("FAIL reset_bus: got %h expected 0", {if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata});
        else passes++;
        checks++;
        if ({if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err} !== '0)
            $display("FAIL reset_resp: got %h expected 0", {if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err});
        else passes++;
        tick();
        reset = 1'b0; if_req = 1'b0;
        @(negedge clk);
        checks++;
        if ({d_gnt, mem_en} !== 2'b11) $display("FAIL first_gnt: got %b expected 11", {d_gnt, mem_en});
        else passes++;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err} !== 2'b10) $display("FAIL first_resp: got %b expected 10", {d_rvalid, d_err});
        else passes++;
        tick();
    endtask

    task automatic test_store_load_fetch();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'h1122334455667788;
        @(negedge clk);
        checks++;
        if ({d_gnt, mem_en, mem_we, mem_addr, mem_wdata} !== {3'b111, 64'h100, 64'h1122334455667788})
            $display("FAIL store_bus: got %h expected %h", {d_gnt, mem_en, mem_we, mem_addr, mem_wdata},
                     {3'b111, 64'h100, 64'h1122334455667788});
        else passes++;
        tick();
        d_we = 1'b0; d_wdata = '0;
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_rdata, d_gnt, mem_we} !== {1'b1, 64'h0, 1'b1, 1'b0})
            $display("FAIL store_resp: got %h expected %h", {d_rvalid, d_rdata, d_gnt, mem_we}, {1'b1, 64'h0, 2'b10});
        else passes++;
        tick();
        d_we = 1'b1; d_addr = 64'h2000; d_wdata = 64'h00000000CAFEF00D;
        @(negedge clk);
        checks++;
        if ({d_rvalid, d_err, d_rdata} !== {2'b10, 64'h1122334455667788})
            $display("FAIL load_data: got %h expected %h", {d_rvalid, d_err, d_rdata}, {2'b10, 64'h1122334455667788});
        else passes++;
        tick();
        idle_inputs();
        if_req = 1'b1; if_addr = 64'h2000;
        @(negedge clk);
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_addr} !== {3'b101, 64'h2000})
            $display("FAIL fetch_gnt: got %h expected %h", {if_gnt, d_gnt, mem_en, mem_addr}, {3'b101, 64'h2000});
        else passes++;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({if_rvalid, if_err, d_rvalid, if_rdata} !== {3'b100, 32'hCAFEF00D})
            $display("FAIL fetch_data: got %h expected %h", {if_rvalid, if_err, d_rvalid, if_rdata}, {3'b100, 32'hCAFEF00D});
        else passes++;
        tick();
    endtask

    task automatic test_starve();
        bit exp_if;
        if_req = 1'b1; if_addr = 64'h2000;
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
        for (int c = 0; c < 6; c++) begin
            exp_if = GUARD && (c == 4);
            @(negedge clk);
            checks++;
            if ({if_gnt, d_gnt} !== {exp_if, !exp_if})
                $display("FAIL starve_c%0d: got %b expected %b", c, {if_gnt, d_gnt}, {exp_if, !exp_if});
            else passes++;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    typedef struct {
        bit          fetch;
        bit          we;
        logic [63:0] addr;
        bit          oor;
    } oor_case_t;

    task automatic test_out_of_range();
        oor_case_t tc [8];
        tc[0] = '{1'b0, 1'b0, 64'h7FFF9, 1'b1};
        tc[1] = '{1'b0, 1'b1, 64'h7FFFC, 1'b1};
        tc[2] = '{1'b0, 1'b0, 64'h7FFF8, 1'b0};
        tc[3] = '{1'b1, 1'b0, 64'h7FFFC, 1'b0};
        tc[4] = '{1'b1, 1'b0, 64'h7FFFD, 1'b1};
        tc[5] = '{1'b1, 1'b0, 64'hFFFFFFFFFFFFFFFE, 1'b1};
        tc[6] = '{1'b0, 1'b0, 64'hFFFFFFFFFFFFFFFC, 1'b1};
        tc[7] = '{1'b0, 1'b0, 64'h103, 1'b0};
        foreach (tc[k]) begin
            idle_inputs();
            if (tc[k].fetch) begin if_req = 1'b1; if_addr = tc[k].addr; end
            else begin d_req = 1'b1; d_we = tc[k].we; d_addr = tc[k].addr; d_wdata = 64'hA5A5; end
            @(negedge clk);
            checks++;
            if ({if_gnt, d_gnt, mem_en, mem_we} !== {tc[k].fetch, !tc[k].fetch, !tc[k].oor, tc[k].we && !tc[k].oor})
                $display("FAIL oor_gnt_%0d: got %b expected %b", k, {if_gnt, d_gnt, mem_en, mem_we},
                         {tc[k].fetch, !tc[k].fetch, !tc[k].oor, tc[k].we && !tc[k].oor});
            else passes++;
            checks++;
            if (mem_addr !== (tc[k].oor ? 64'h0 : tc[k].addr))
                $display("FAIL oor_addr_%0d: got %h expected %h", k, mem_addr, tc[k].oor ? 64'h0 : tc[k].addr);
            else passes++;
            tick();
            idle_inputs();
            @(negedge clk);
            checks++;
            if (tc[k].fetch && ({if_rvalid, if_err, d_rvalid} !== {1'b1, tc[k].oor, 1'b0}))
                $display("FAIL oor_resp_%0d: got %b expected %b", k, {if_rvalid, if_err, d_rvalid}, {1'b1, tc[k].oor, 1'b0});
            else if (!tc[k].fetch && ({d_rvalid, d_err, if_rvalid} !== {1'b1, tc[k].oor, 1'b0}))
                $display("FAIL oor_resp_%0d: got %b expected %b", k, {d_rvalid, d_err, if_rvalid}, {1'b1, tc[k].oor, 1'b0});
            else passes++;
            if (tc[k].oor) begin
                checks++;
                if ({if_rdata, d_rdata} !== '0)
                    $display("FAIL oor_rdata_%0d: got %h expected 0", k, {if_rdata, d_rdata});
                else passes++;
            end
            tick();
        end
    endtask

    task automatic test_alternating();
        int gcount = 0;
        bit prev_if = 1'b0, prev_d = 1'b0, even;
        for (int c = 0; c <= 10; c++) begin
            even = (c % 2 == 0);
            idle_inputs();
            if (c < 10 && even) begin if_req = 1'b1; if_addr = 64'h2000; end
            if (c < 10 && !even) begin d_req = 1'b1; d_addr = 64'h100; end
            @(negedge clk);
            if (c < 10) begin
                checks++;
                if ({if_gnt, d_gnt} !== {even, !even})
                    $display("FAIL alt_gnt_%0d: got %b expected %b", c, {if_gnt, d_gnt}, {even, !even});
                else passes++;
            end
            gcount += int'(if_gnt) + int'(d_gnt);
            checks++;
            if ({if_rvalid, d_rvalid} !== {prev_if, prev_d})
                $display("FAIL alt_rvalid_%0d: got %b expected %b", c, {if_rvalid, d_rvalid}, {prev_if, prev_d});
            else passes++;
            if (prev_if) begin
                checks++;
                if (if_rdata !== 32'hCAFEF00D) $display("FAIL alt_if_data_%0d: got %h expected cafef00d", c, if_rdata);
                else passes++;
            end
            if (prev_d) begin
                checks++;
                if (d_rdata !== 64'h1122334455667788)
                    $display("FAIL alt_d_data_%0d: got %h expected 1122334455667788", c, d_rdata);
                else passes++;
            end
            prev_if = (c < 10) && even;
            prev_d  = (c < 10) && !even;
            tick();
        end
        checks++;
        if (gcount != 10) $display("FAIL alt_count: got %0d expected 10", gcount);
        else passes++;
    endtask

    task automatic test_reset_midload();
        idle_inputs();
        d_req = 1'b1; d_addr = 64'h100;
        @(negedge clk);
        checks++;
        if (d_gnt !== 1'b1) $display("FAIL midrst_gnt: got %b expected 1", d_gnt);
        else passes++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata, if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err} !== '0)
            $display("FAIL midrst_outs: got %h expected 0",
                     {if_gnt, d_gnt, mem_en, mem_we, mem_addr, mem_wdata, if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err});
        else passes++;
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({if_rvalid, d_rvalid, d_rdata, if_rdata} !== '0)
            $display("FAIL midrst_hold: got %h expected 0", {if_rvalid, d_rvalid, d_rdata, if_rdata});
        else passes++;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({if_rvalid, d_rvalid} !== 2'b00)
                $display("FAIL midrst_drop_%0d: got %b expected 00", c, {if_rvalid, d_rvalid});
            else passes++;
            tick();
        end
    endtask

    function automatic logic [63:0] rand_addr();
        int unsigned sel;
        sel = $urandom_range(0, 15);
        if (sel == 0) return MEMB - 64'($urandom_range(1, 12));
        if (sel == 1) return 64'hFFFFFFFFFFFFFFF0 + 64'($urandom_range(0, 15));
        return 64'h400 + 64'($urandom_range(0, 248));
    endfunction

    // Reference: data first unless fetch has watched STARVE consecutive data grants.
    task automatic test_random();
        int          waited = 0;
        int          pend_kind = 0;
        bit          pend_err = 1'b0;
        logic [63:0] pend_data = '0;
        bit          e_if, e_d, e_ioor, e_door, e_en, e_we;
        logic [63:0] e_addr, e_wd;
        logic [101:0] e_resp;
        idle_inputs();
        for (int c = 0; c < 400; c++) begin
            if (!if_req || e_if) begin
                if_req = ($urandom_range(0, 1) == 1); if_addr = rand_addr();
            end
            if (!d_req || e_d) begin
                d_req = ($urandom_range(0, 3) != 0); d_we = ($urandom_range(0, 2) == 0);
                d_addr = rand_addr(); d_wdata = {$urandom, $urandom};
            end
            @(negedge clk);
            e_if   = if_req && (!d_req || (GUARD && waited == int'(STARVE)));
            e_d    = d_req && !e_if;
            e_ioor = if_addr > MEMB - 64'd4;
            e_door = d_addr > MEMB - 64'd8;
            e_en   = (e_if && !e_ioor) || (e_d && !e_door);
            e_we   = e_d && d_we && !e_door;
            e_addr = !e_en ? 64'h0 : (e_if ? if_addr : d_addr);
            e_wd   = e_we ? d_wdata : 64'h0;
            e_resp = {pend_kind == 1, (pend_kind == 1) ? pend_data[31:0] : 32'h0, pend_kind == 1 && pend_err,
                      pend_kind == 2, (pend_kind == 2) ? pend_data : 64'h0, pend_kind == 2 && pend_err};
            checks++;
            if ({if_gnt, d_gnt} !== {e_if, e_d})
                $display("FAIL rand_gnt_%0d: got %b expected %b", c, {if_gnt, d_gnt}, {e_if, e_d});
            else passes++;
            checks++;
            if ({mem_en, mem_we, mem_addr, mem_wdata} !== {e_en, e_we, e_addr, e_wd})
                $display("FAIL rand_mem_%0d: got %h expected %h", c, {mem_en, mem_we, mem_addr, mem_wdata}, {e_en, e_we, e_addr, e_wd});
            else passes++;
            checks++;
            if ({if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err} !== e_resp)
                $display("FAIL rand_resp_%0d: got %h expected %h", c, {if_rvalid, if_rdata, if_err, d_rvalid, d_rdata, d_err}, e_resp);
            else passes++;
            pend_kind = e_if ? 1 : (e_d ? 2 : 0);
            pend_err  = e_if ? e_ioor : e_door;
            pend_data = '0;
            if (e_if && !e_ioor) pend_data = {32'h0, ref_rd64(if_addr)[31:0]};
            if (e_d && !e_door && !d_we) pend_data = ref_rd64(d_addr);
            if (e_we) for (int i = 0; i < 8; i++) ref_mem[d_addr + 64'(i)] = d_wdata[8*i +: 8];
            if (!if_req || e_if) waited = 0;
            else if (e_d) waited++;
            tick();
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        reset = 1'b1;
        idle_inputs();
        test_reset();
        test_store_load_fetch();
        test_starve();
        test_out_of_range();
        test_alternating();
        test_reset_midload();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
